// File: rtl/tim_alu_pkg.sv
`default_nettype none
// ============================================================================
// Module : tim_alu_pkg
// Brief  : Shared opcode encoding and status-flag bundle for the pipelined ALU.
// Rev    : 1.0  initial release
// ============================================================================
package tim_alu_pkg;

    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_AND = 3'b010,
        OP_OR  = 3'b011,
        OP_XOR = 3'b100,
        OP_NOT = 3'b101,
        OP_SHL = 3'b110,
        OP_SHR = 3'b111
    } opcode_e;

    typedef struct packed {
        logic zero;
        logic carry;
        logic ovf;
    } alu_flags_t;

endpackage
`default_nettype wire

// File: rtl/tim_alu_pipe_if.sv
`default_nettype none
// ============================================================================
// Module : tim_alu_pipe_if
// Brief  : Operand-issue and result valid/ready bundle for tim_alu_pipe.
// Rev    : 1.0  initial release
// ============================================================================
interface tim_alu_pipe_if #(
    parameter int WIDTH = 8
);
    import tim_alu_pkg::*;

    logic             in_valid;
    logic             in_ready;
    opcode_e          in_opcode;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;

    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_result;
    logic             out_zero;
    logic             out_carry;
    logic             out_ovf;

    // master = issue/writeback side, slave = the ALU pipeline
    modport master (
        output in_valid, in_opcode, in_a, in_b, out_ready,
        input  in_ready, out_valid, out_result, out_zero, out_carry, out_ovf
    );

    modport slave (
        input  in_valid, in_opcode, in_a, in_b, out_ready,
        output in_ready, out_valid, out_result, out_zero, out_carry, out_ovf
    );

endinterface
`default_nettype wire

// File: rtl/tim_alu_core.sv
`default_nettype none
// ============================================================================
// Module : tim_alu_core
// Brief  : Combinational ALU datapath (8 ops). Define TIM_ALU_SAT_EN for
//          saturating ADD/SUB; otherwise they wrap.
// Rev    : 1.0  initial release
// ============================================================================
module tim_alu_core
    import tim_alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  opcode_e          opcode_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic [WIDTH-1:0] result_o,
    output alu_flags_t       flags_o
);

    localparam int SHW = $clog2(WIDTH);
    localparam int MSB = WIDTH - 1;

    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   diff;
    logic [SHW-1:0]   shamt;

    assign sum   = {1'b0, a_i} + {1'b0, b_i};
    assign diff  = {1'b0, a_i} - {1'b0, b_i};
    assign shamt = b_i[SHW-1:0];

    always_comb begin
        result_o = '0;
        flags_o  = '0;
        case (opcode_i)
            OP_ADD: begin
                flags_o.carry = sum[WIDTH];
                flags_o.ovf   = (a_i[MSB] == b_i[MSB]) && (sum[MSB] != a_i[MSB]);
`ifdef TIM_ALU_SAT_EN
                result_o      = sum[WIDTH] ? {WIDTH{1'b1}} : sum[WIDTH-1:0];
`else
                result_o      = sum[WIDTH-1:0];
`endif
            end
            OP_SUB: begin
                // bit WIDTH of the extended difference is the borrow
                flags_o.carry = diff[WIDTH];
                flags_o.ovf   = (a_i[MSB] == ~b_i[MSB]) && (diff[MSB] != a_i[MSB]);
`ifdef TIM_ALU_SAT_EN
                result_o      = diff[WIDTH] ? {WIDTH{1'b0}} : diff[WIDTH-1:0];
`else
                result_o      = diff[WIDTH-1:0];
`endif
            end
            OP_AND:  result_o = a_i & b_i;
            OP_OR:   result_o = a_i | b_i;
            OP_XOR:  result_o = a_i ^ b_i;
            OP_NOT:  result_o = ~a_i;
            OP_SHL:  result_o = a_i << shamt;
            OP_SHR:  result_o = a_i >> shamt;
            default: result_o = '0;
        endcase
        flags_o.zero = (result_o == '0);
    end

endmodule
`default_nettype wire

// File: rtl/tim_alu_pipe.sv
`default_nettype none
// ============================================================================
// Module : tim_alu_pipe
// Brief  : 2-stage valid/ready ALU pipeline around tim_alu_core.
//          Optional macro TIM_ALU_SAT_EN selects saturating ADD/SUB.
// Rev    : 1.0  initial release
// ============================================================================
module tim_alu_pipe
    import tim_alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    tim_alu_pipe_if.slave  bus
);

    logic             s1_valid_q, s1_valid_d;
    opcode_e          s1_op_q,    s1_op_d;
    logic [WIDTH-1:0] s1_a_q,     s1_a_d;
    logic [WIDTH-1:0] s1_b_q,     s1_b_d;

    logic             s2_valid_q,  s2_valid_d;
    logic [WIDTH-1:0] s2_result_q, s2_result_d;
    alu_flags_t       s2_flags_q,  s2_flags_d;

    logic             s1_load;
    logic             s2_load;
    logic [WIDTH-1:0] core_result;
    alu_flags_t       core_flags;

    tim_alu_core #(
        .WIDTH    (WIDTH)
    ) u_core (
        .opcode_i (s1_op_q),
        .a_i      (s1_a_q),
        .b_i      (s1_b_q),
        .result_o (core_result),
        .flags_o  (core_flags)
    );

    // Readiness depends only on registered state and out_ready, never in_valid
    assign s2_load = !s2_valid_q || bus.out_ready;
    assign s1_load = !s1_valid_q || s2_load;

    assign bus.in_ready   = !s1_valid_q || !s2_valid_q || bus.out_ready;
    assign bus.out_valid  = s2_valid_q;
    assign bus.out_result = s2_result_q;
    assign bus.out_zero   = s2_flags_q.zero;
    assign bus.out_carry  = s2_flags_q.carry;
    assign bus.out_ovf    = s2_flags_q.ovf;

    always_comb begin
        s1_valid_d  = s1_valid_q;
        s1_op_d     = s1_op_q;
        s1_a_d      = s1_a_q;
        s1_b_d      = s1_b_q;
        s2_valid_d  = s2_valid_q;
        s2_result_d = s2_result_q;
        s2_flags_d  = s2_flags_q;

        // Bubbles leave the last result/flags visible on out_*
        if (s2_load) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                s2_result_d = core_result;
                s2_flags_d  = core_flags;
            end
        end

        if (s1_load) begin
            s1_valid_d = bus.in_valid;
            if (bus.in_valid) begin
                s1_op_d = bus.in_opcode;
                s1_a_d  = bus.in_a;
                s1_b_d  = bus.in_b;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q  <= 1'b0;
            s1_op_q     <= OP_ADD;
            s1_a_q      <= '0;
            s1_b_q      <= '0;
            s2_valid_q  <= 1'b0;
            s2_result_q <= '0;
            s2_flags_q  <= '0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_op_q     <= s1_op_d;
            s1_a_q      <= s1_a_d;
            s1_b_q      <= s1_b_d;
            s2_valid_q  <= s2_valid_d;
            s2_result_q <= s2_result_d;
            s2_flags_q  <= s2_flags_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_tim_alu_pipe.sv
`default_nettype none
// ============================================================================
// Module : tb_tim_alu_pipe
// Brief  : Directed, table-driven self-checking bench for tim_alu_pipe (WIDTH=8).
// Rev    : 1.0  initial release
// ============================================================================
module tb_tim_alu_pipe;
    import tim_alu_pkg::*;

    typedef struct {
        logic [2:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] res;
        logic       z;
        logic       c;
        logic       v;
    } vec_t;

    localparam int NV = 13;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    tim_alu_pipe_if #(.WIDTH(8)) bus ();

    tim_alu_pipe #(.WIDTH(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    logic [10:0] obs;
    assign obs = {bus.out_result, bus.out_zero, bus.out_carry, bus.out_ovf};

    int          n_checks = 0;
    int          n_errors = 0;
    vec_t        vecs [NV];
    logic [2:0]  tp_op  [4];
    logic [7:0]  tp_a   [4];
    logic [7:0]  tp_b   [4];
    logic [7:0]  tp_exp [4];
    logic [2:0]  st_op  [3];
    logic [7:0]  st_a   [3];
    logic [7:0]  st_b   [3];
    logic [7:0]  drn    [4];
    logic [10:0] held;
    logic        got;
    logic        seen;
    logic        stable_ok;
    logic        stale;
    int          acc;
    int          n_drn;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic idle();
        bus.in_valid  = 1'b0;
        bus.in_opcode = OP_ADD;
        bus.in_a      = 8'h00;
        bus.in_b      = 8'h00;
    endtask

    task automatic drive(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        bus.in_valid  = 1'b1;
        bus.in_opcode = opcode_e'(op);
        bus.in_a      = a;
        bus.in_b      = b;
    endtask

    initial begin
`ifdef TIM_ALU_SAT_EN
        vecs[0]  = '{3'b000, 8'hF0, 8'h20, 8'hFF, 1'b0, 1'b1, 1'b0};
        vecs[1]  = '{3'b001, 8'h05, 8'h07, 8'h00, 1'b1, 1'b1, 1'b0};
        vecs[11] = '{3'b000, 8'h80, 8'h80, 8'hFF, 1'b0, 1'b1, 1'b1};
`else
        vecs[0]  = '{3'b000, 8'hF0, 8'h20, 8'h10, 1'b0, 1'b1, 1'b0};
        vecs[1]  = '{3'b001, 8'h05, 8'h07, 8'hFE, 1'b0, 1'b1, 1'b0};
        vecs[11] = '{3'b000, 8'h80, 8'h80, 8'h00, 1'b1, 1'b1, 1'b1};
`endif
        vecs[2]  = '{3'b001, 8'h80, 8'h01, 8'h7F, 1'b0, 1'b0, 1'b1};
        vecs[3]  = '{3'b010, 8'h0F, 8'hF0, 8'h00, 1'b1, 1'b0, 1'b0};
        vecs[4]  = '{3'b101, 8'hFF, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0};
        vecs[5]  = '{3'b000, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b0, 1'b1};
        vecs[6]  = '{3'b011, 8'h0A, 8'h50, 8'h5A, 1'b0, 1'b0, 1'b0};
        vecs[7]  = '{3'b100, 8'hFF, 8'h0F, 8'hF0, 1'b0, 1'b0, 1'b0};
        vecs[8]  = '{3'b110, 8'h81, 8'h03, 8'h08, 1'b0, 1'b0, 1'b0};
        vecs[9]  = '{3'b111, 8'h81, 8'h0B, 8'h10, 1'b0, 1'b0, 1'b0};
        vecs[10] = '{3'b001, 8'h10, 8'h10, 8'h00, 1'b1, 1'b0, 1'b0};
        vecs[12] = '{3'b110, 8'h01, 8'h0F, 8'h80, 1'b0, 1'b0, 1'b0};

        tp_op[0] = 3'b000; tp_a[0] = 8'h01; tp_b[0] = 8'h02; tp_exp[0] = 8'h03;
        tp_op[1] = 3'b001; tp_a[1] = 8'h09; tp_b[1] = 8'h04; tp_exp[1] = 8'h05;
        tp_op[2] = 3'b100; tp_a[2] = 8'hF0; tp_b[2] = 8'hFF; tp_exp[2] = 8'h0F;
        tp_op[3] = 3'b110; tp_a[3] = 8'h81; tp_b[3] = 8'h03; tp_exp[3] = 8'h08;

        st_op[0] = 3'b000; st_a[0] = 8'h11; st_b[0] = 8'h22;
        st_op[1] = 3'b011; st_a[1] = 8'h40; st_b[1] = 8'h04;
        st_op[2] = 3'b010; st_a[2] = 8'hFF; st_b[2] = 8'h3C;

        // Reset state
        rst_n = 1'b0;
        bus.out_ready = 1'b1;
        idle();
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_outputs",   32'(obs),           32'd0);
        check("rst_in_ready",  32'(bus.in_ready),  32'd1);
        @(negedge clk);
        rst_n = 1'b1;

        // Single-beat vector table
        for (int i = 0; i < NV; i++) begin
            @(posedge clk); #1;
            drive(vecs[i].op, vecs[i].a, vecs[i].b);
            @(posedge clk); #1;
            idle();
            got = 1'b0;
            for (int k = 0; k < 8 && !got; k++) begin
                if (bus.out_valid) got = 1'b1;
                else begin
                    @(posedge clk); #1;
                end
            end
            check($sformatf("vec%0d_valid", i), 32'(got), 32'd1);
            if (got)
                check($sformatf("vec%0d_out", i), 32'(obs),
                      32'({vecs[i].res, vecs[i].z, vecs[i].c, vecs[i].v}));
        end

        // Back-to-back issue: results on cycles 2..5 in order
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            check($sformatf("tp_valid%0d", i), 32'(bus.out_valid), 32'(i >= 2 && i <= 5));
            if (i >= 2 && i <= 5)
                check($sformatf("tp_result%0d", i), 32'(bus.out_result), 32'(tp_exp[i-2]));
            if (i < 4) drive(tp_op[i], tp_a[i], tp_b[i]);
            else       idle();
        end

        // Stall with in_valid held high: exactly two beats enter
        acc = 0; seen = 1'b0; stable_ok = 1'b1; held = '0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            if (bus.out_valid) begin
                if (seen && obs != held) stable_ok = 1'b0;
                held = obs;
                seen = 1'b1;
            end
            bus.out_ready = 1'b0;
            drive(st_op[acc < 3 ? acc : 2], st_a[acc < 3 ? acc : 2], st_b[acc < 3 ? acc : 2]);
            #1;
            if (bus.in_ready) acc++;
        end
        check("stall_accepted", 32'(acc),           32'd2);
        check("stall_in_ready", 32'(bus.in_ready),  32'd0);
        check("stall_stable",   32'(stable_ok),     32'd1);
        check("stall_head",     32'(held),          32'({8'h33, 3'b000}));

        n_drn = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            idle();
            bus.out_ready = 1'b1;
            #1;
            if (bus.out_valid) begin
                if (n_drn < 4) drn[n_drn] = bus.out_result;
                n_drn++;
            end
        end
        check("drain_count", 32'(n_drn), 32'd2);
        if (n_drn >= 2) begin
            check("drain_first",  32'(drn[0]), 32'h33);
            check("drain_second", 32'(drn[1]), 32'h44);
        end

        // Asynchronous reset with two beats in flight
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        drive(3'b000, 8'hF0, 8'h20);
        @(posedge clk); #1;
        drive(3'b001, 8'h80, 8'h01);
        @(posedge clk); #1;
        idle();
        check("inflight_valid", 32'(bus.out_valid), 32'd1);
`ifdef TIM_ALU_SAT_EN
        check("inflight_out", 32'(obs), 32'({8'hFF, 3'b010}));
`else
        check("inflight_out", 32'(obs), 32'({8'h10, 3'b010}));
`endif
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_out_valid", 32'(bus.out_valid), 32'd0);
        check("arst_outputs",   32'(obs),           32'd0);
        check("arst_in_ready",  32'(bus.in_ready),  32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        stale = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            if (bus.out_valid) stale = 1'b1;
        end
        check("no_stale_beat", 32'(stale), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
